// File: rtl/stoplight_pkg.sv
// Shared types and constants for the stoplight monitor.
// Light patterns are packed as {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}.
package stoplight_pkg;

  // Decoded intersection phase, in the order the controller must cycle through
  typedef enum logic [1:0] {
    PH_A = 2'd0,  // NS green,  EW red
    PH_B = 2'd1,  // NS yellow, EW red
    PH_C = 2'd2,  // EW green,  NS red
    PH_D = 2'd3   // EW yellow, NS red
  } phase_e;

  // Last-error code reported to the supervisor
  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_ILLEGAL  = 3'd1,
    ERR_CONFLICT = 3'd2,
    ERR_SEQUENCE = 3'd3,
    ERR_TIMING   = 3'd4
  } err_code_e;

  // Monitor tracking state
  typedef enum logic {
    ST_SYNC  = 1'b0,  // waiting for a legal pattern to lock onto
    ST_TRACK = 1'b1   // locked onto a phase, checking dwell and order
  } mon_state_e;

  // Bit positions of the two red lamps inside the packed pattern
  localparam int LT_NS_RED = 5;
  localparam int LT_EW_RED = 2;

  // The only four legal light patterns
  localparam logic [5:0] PAT_A = 6'b001_100;
  localparam logic [5:0] PAT_B = 6'b010_100;
  localparam logic [5:0] PAT_C = 6'b100_001;
  localparam logic [5:0] PAT_D = 6'b100_010;

  // Phase that must legally follow the given one (wraps D -> A)
  function automatic phase_e next_phase(input phase_e cur);
    logic [1:0] nxt;
    nxt = cur + 2'd1;
    return phase_e'(nxt);
  endfunction

  // Highest-priority code among the errors raised in one cycle
  function automatic err_code_e err_priority(input logic ill, input logic con,
                                             input logic seq, input logic tim);
    err_code_e code;
    if (con) begin
      code = ERR_CONFLICT;
    end else if (ill) begin
      code = ERR_ILLEGAL;
    end else if (seq) begin
      code = ERR_SEQUENCE;
    end else if (tim) begin
      code = ERR_TIMING;
    end else begin
      code = ERR_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/stoplight_decode.sv
// Combinational light-pattern classifier: six lamps -> {legal, conflict, phase}.
// A conflict means neither direction shows red; such a pattern is never legal.
module stoplight_decode
  import stoplight_pkg::*;
(
  input  logic [5:0] lights,
  output logic       legal,
  output logic       conflict,
  output phase_e     phase
);

  // Match the pattern against the four legal phases; anything else is illegal
  always_comb begin
    legal = 1'b1;
    phase = PH_A;
    case (lights)
      PAT_A: begin
        legal = 1'b1;
        phase = PH_A;
      end
      PAT_B: begin
        legal = 1'b1;
        phase = PH_B;
      end
      PAT_C: begin
        legal = 1'b1;
        phase = PH_C;
      end
      PAT_D: begin
        legal = 1'b1;
        phase = PH_D;
      end
      default: begin
        legal = 1'b0;
        phase = PH_A;
      end
    endcase
  end

  assign conflict = ~lights[LT_NS_RED] & ~lights[LT_EW_RED];

endmodule

// File: rtl/stoplight_monitor.sv
// Passive monitor for the six stoplight lamp outputs.
// Registers the lamps once, decodes them into a phase, measures the dwell of
// each phase and reports illegal/conflicting patterns, out-of-order phases and
// dwell-time violations. Pin-to-flag latency is two clock cycles.
// Build option STOPLIGHT_MON_ERRCNT_EN: when defined, err_count is a saturating
// count of cycles carrying at least one error pulse (cleared by reset only);
// otherwise err_count is a constant zero.
module stoplight_monitor
  import stoplight_pkg::*;
#(
  parameter int DUR_A = 11,
  parameter int DUR_B = 4,
  parameter int DUR_C = 7,
  parameter int DUR_D = 4,
  parameter int TOL   = 0,
  parameter int DW_W  = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ns_red,
  input  logic            ns_yellow,
  input  logic            ns_green,
  input  logic            ew_red,
  input  logic            ew_yellow,
  input  logic            ew_green,
  input  logic            clr_err,
  output logic [1:0]      phase,
  output logic            phase_valid,
  output logic [DW_W-1:0] dwell,
  output logic            err_illegal,
  output logic            err_conflict,
  output logic            err_sequence,
  output logic            err_timing,
  output logic            err_sticky,
  output logic [2:0]      err_code,
  output logic [7:0]      err_count
);

  localparam logic [DW_W-1:0] DWELL_ZERO = {DW_W{1'b0}};
  localparam logic [DW_W-1:0] DWELL_ONE  = {{(DW_W-1){1'b0}}, 1'b1};
  localparam logic [DW_W-1:0] DWELL_MAX  = {DW_W{1'b1}};

  // Nominal dwell of a phase
  function automatic int dur_of(input phase_e p);
    int d;
    case (p)
      PH_A:    d = DUR_A;
      PH_B:    d = DUR_B;
      PH_C:    d = DUR_C;
      PH_D:    d = DUR_D;
      default: d = DUR_A;
    endcase
    return d;
  endfunction

  // Input sampling
  logic [5:0]      lights_r;
  logic            sample_valid_r;  // lights_r holds a real sample, not reset junk

  // Tracking state
  mon_state_e      state_r;
  phase_e          phase_r;
  logic [DW_W-1:0] dwell_r;
  logic            valid_r;
  logic            first_phase_r;   // current phase was entered without a checked predecessor
  logic            stuck_r;         // overstay already reported for the current phase
  logic            in_illegal_r;    // an illegal run is in progress (report its entry only)

  // Error outputs
  logic            ill_r;
  logic            con_r;
  logic            seq_r;
  logic            tim_r;
  logic            sticky_r;
  err_code_e       code_r;

  // Decoder results
  logic            dec_legal_s;
  logic            dec_conflict_s;
  phase_e          dec_phase_s;

  // Per-cycle error decisions
  logic [DW_W-1:0] dwell_inc_s;
  int              dur_hi_s;
  int              dur_lo_s;
  logic            same_s;
  logic            succ_s;
  logic            timed_s;
  logic            ill_s;
  logic            con_s;
  logic            seq_s;
  logic            tim_s;
  logic            any_err_s;
  err_code_e       code_next_s;

  stoplight_decode u_decode (
    .lights   (lights_r),
    .legal    (dec_legal_s),
    .conflict (dec_conflict_s),
    .phase    (dec_phase_s)
  );

  // Classify the sampled pattern against the tracked phase and decide which errors fire
  always_comb begin
    dwell_inc_s = (dwell_r == DWELL_MAX) ? dwell_r : (dwell_r + DWELL_ONE);
    dur_hi_s    = dur_of(phase_r) + TOL;
    dur_lo_s    = dur_of(phase_r) - TOL;
    same_s      = (dec_phase_s == phase_r);
    succ_s      = (dec_phase_s == next_phase(phase_r));
    timed_s     = ~first_phase_r & ~stuck_r;
    ill_s       = 1'b0;
    con_s       = 1'b0;
    seq_s       = 1'b0;
    tim_s       = 1'b0;
    if (!sample_valid_r) begin
      ill_s = 1'b0;
    end else if (!dec_legal_s) begin
      ill_s = ~in_illegal_r;
      con_s = ~in_illegal_r & dec_conflict_s;
    end else if (state_r != ST_TRACK) begin
      seq_s = 1'b0;
    end else if (same_s) begin
      tim_s = timed_s & (int'(dwell_inc_s) > dur_hi_s);
    end else if (succ_s) begin
      tim_s = timed_s & (int'(dwell_r) < dur_lo_s);
    end else begin
      seq_s = 1'b1;
    end
  end

  // Merge the error pulses and pick the code to report
  always_comb begin
    any_err_s   = ill_s | con_s | seq_s | tim_s;
    code_next_s = err_priority(ill_s, con_s, seq_s, tim_s);
  end

  // Input register, SYNC/TRACK tracker, dwell counter and error/status registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lights_r       <= 6'b000000;
      sample_valid_r <= 1'b0;
      state_r        <= ST_SYNC;
      phase_r        <= PH_A;
      dwell_r        <= DWELL_ZERO;
      valid_r        <= 1'b0;
      first_phase_r  <= 1'b1;
      stuck_r        <= 1'b0;
      in_illegal_r   <= 1'b0;
      ill_r          <= 1'b0;
      con_r          <= 1'b0;
      seq_r          <= 1'b0;
      tim_r          <= 1'b0;
      sticky_r       <= 1'b0;
      code_r         <= ERR_NONE;
    end else begin
      lights_r       <= {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};
      sample_valid_r <= 1'b1;

      ill_r <= ill_s;
      con_r <= con_s;
      seq_r <= seq_s;
      tim_r <= tim_s;

      // A new error always beats a simultaneous clear
      if (any_err_s) begin
        sticky_r <= 1'b1;
        code_r   <= code_next_s;
      end else if (clr_err) begin
        sticky_r <= 1'b0;
        code_r   <= ERR_NONE;
      end

      if (sample_valid_r) begin
        if (!dec_legal_s) begin
          // Drop lock; the next legal pattern starts a fresh, untimed phase
          in_illegal_r <= 1'b1;
          state_r      <= ST_SYNC;
          valid_r      <= 1'b0;
          dwell_r      <= DWELL_ZERO;
          stuck_r      <= 1'b0;
        end else begin
          in_illegal_r <= 1'b0;
          case (state_r)
            ST_SYNC: begin
              state_r       <= ST_TRACK;
              phase_r       <= dec_phase_s;
              dwell_r       <= DWELL_ONE;
              valid_r       <= 1'b1;
              first_phase_r <= 1'b1;
              stuck_r       <= 1'b0;
            end
            ST_TRACK: begin
              if (same_s) begin
                dwell_r <= dwell_inc_s;
                if (tim_s) begin
                  stuck_r <= 1'b1;
                end
              end else if (succ_s) begin
                phase_r       <= dec_phase_s;
                dwell_r       <= DWELL_ONE;
                first_phase_r <= 1'b0;
                stuck_r       <= 1'b0;
              end else begin
                // Out-of-order entry: the new phase cannot be timed reliably
                phase_r       <= dec_phase_s;
                dwell_r       <= DWELL_ONE;
                first_phase_r <= 1'b1;
                stuck_r       <= 1'b0;
              end
            end
            default: begin
              state_r <= ST_SYNC;
              valid_r <= 1'b0;
              dwell_r <= DWELL_ZERO;
            end
          endcase
        end
      end
    end
  end

  assign phase        = phase_r;
  assign phase_valid  = valid_r;
  assign dwell        = dwell_r;
  assign err_illegal  = ill_r;
  assign err_conflict = con_r;
  assign err_sequence = seq_r;
  assign err_timing   = tim_r;
  assign err_sticky   = sticky_r;
  assign err_code     = code_r;

`ifdef STOPLIGHT_MON_ERRCNT_EN
  logic [7:0] err_count_r;

  // Saturating count of cycles that carry at least one error pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_count_r <= 8'h00;
    end else if (any_err_s && (err_count_r != 8'hFF)) begin
      err_count_r <= err_count_r + 8'h01;
    end
  end

  assign err_count = err_count_r;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_stoplight_monitor.sv
// Scoreboard bench for stoplight_monitor. The driver applies one lamp pattern
// per cycle, advances a phase/run-length reference model and queues the
// outputs expected one cycle later; a monitor on the falling edge pops and
// compares them against the DUT.
module tb_stoplight_monitor;

  localparam int TOL = 0;
  localparam logic [5:0] PA  = 6'b001_100;
  localparam logic [5:0] PB  = 6'b010_100;
  localparam logic [5:0] PC  = 6'b100_001;
  localparam logic [5:0] PD  = 6'b100_010;
  localparam logic [5:0] PGG = 6'b001_001;

  int         dur_tab [4] = '{11, 4, 7, 4};
  logic [5:0] pat_tab [4] = '{PA, PB, PC, PD};

  logic       clk;
  logic       reset_n;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic       clr_err;
  logic [1:0] phase;
  logic       phase_valid;
  logic [7:0] dwell;
  logic       err_illegal, err_conflict, err_sequence, err_timing, err_sticky;
  logic [2:0] err_code;
  logic [7:0] err_count;

  stoplight_monitor #(
    .DUR_A(11), .DUR_B(4), .DUR_C(7), .DUR_D(4), .TOL(TOL), .DW_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .clr_err(clr_err),
    .phase(phase), .phase_valid(phase_valid), .dwell(dwell),
    .err_illegal(err_illegal), .err_conflict(err_conflict),
    .err_sequence(err_sequence), .err_timing(err_timing),
    .err_sticky(err_sticky), .err_code(err_code), .err_count(err_count)
  );

  typedef struct {
    int due;
    int ph;
    bit vld;
    int dw;
    bit ill, con, seq, tim, sticky;
    int code;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: the run of identical legal patterns being watched
  bit   m_locked;     // a legal run is being followed
  int   m_ph;         // phase of that run (kept after losing lock)
  int   m_run;        // length of the run, saturating at 255
  bit   m_untimed;    // run began without a properly ordered predecessor
  bit   m_reported;   // overstay of this run already reported
  bit   m_bad_run;    // inside a run of illegal patterns
  bit   m_sticky;
  int   m_code;
  int   m_cnt;
  logic [5:0] prev_pat;
  bit   prev_ok;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lookup(input logic [5:0] p);
    for (int i = 0; i < 4; i++) begin
      if (pat_tab[i] == p) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_ph = 0; m_run = 0; m_untimed = 1; m_reported = 0;
    m_bad_run = 0; m_sticky = 0; m_code = 0; m_cnt = 0; prev_ok = 0;
  endtask

  // Apply one cycle of stimulus and queue the outputs expected after the next edge
  task automatic drive(input logic [5:0] pat, input logic clr, input logic rst);
    exp_t e;
    int   idx;
    bit   ill, con, seq, tim;
    @(posedge clk);
    #1;
    {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = pat;
    clr_err = clr;
    reset_n = rst;
    ill = 0; con = 0; seq = 0; tim = 0;
    if (!rst) begin
      model_reset();
    end else begin
      if (prev_ok) begin
        idx = lookup(prev_pat);
        if (idx < 0) begin
          if (!m_bad_run) begin
            ill = 1;
            con = !prev_pat[5] && !prev_pat[2];
          end
          m_bad_run = 1; m_locked = 0; m_run = 0;
        end else begin
          m_bad_run = 0;
          if (!m_locked) begin
            m_locked = 1; m_ph = idx; m_run = 1; m_untimed = 1; m_reported = 0;
          end else if (idx == m_ph) begin
            if (m_run < 255) m_run++;
            if (!m_untimed && !m_reported && m_run > dur_tab[m_ph] + TOL) begin
              tim = 1; m_reported = 1;
            end
          end else if (idx == (m_ph + 1) % 4) begin
            if (!m_untimed && !m_reported && m_run < dur_tab[m_ph] - TOL) tim = 1;
            m_ph = idx; m_run = 1; m_untimed = 0; m_reported = 0;
          end else begin
            seq = 1;
            m_ph = idx; m_run = 1; m_untimed = 1; m_reported = 0;
          end
        end
      end
      if (ill || con || seq || tim) begin
        m_sticky = 1;
        m_code = con ? 2 : ill ? 1 : seq ? 3 : 4;
`ifdef STOPLIGHT_MON_ERRCNT_EN
        if (m_cnt < 255) m_cnt++;
`endif
      end else if (clr) begin
        m_sticky = 0; m_code = 0;
      end
      prev_pat = pat;
      prev_ok  = 1;
    end
    e.due = cyc + 1; e.ph = m_ph; e.vld = m_locked; e.dw = m_run;
    e.ill = ill; e.con = con; e.seq = seq; e.tim = tim;
    e.sticky = m_sticky; e.code = m_code; e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic hold(input logic [5:0] pat, input int n);
    for (int i = 0; i < n; i++) drive(pat, 1'b0, 1'b1);
  endtask

  task automatic nominal_round();
    hold(PA, 11); hold(PB, 4); hold(PC, 7); hold(PD, 4);
  endtask

  // Compare each expected entry against the DUT once its cycle comes up
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due != cyc) begin
        chk("sb_late_entry", e.due, cyc);
      end else begin
        chk("phase",        int'(phase),        e.ph);
        chk("phase_valid",  int'(phase_valid),  int'(e.vld));
        chk("dwell",        int'(dwell),        e.dw);
        chk("err_illegal",  int'(err_illegal),  int'(e.ill));
        chk("err_conflict", int'(err_conflict), int'(e.con));
        chk("err_sequence", int'(err_sequence), int'(e.seq));
        chk("err_timing",   int'(err_timing),   int'(e.tim));
        chk("err_sticky",   int'(err_sticky),   int'(e.sticky));
        chk("err_code",     int'(err_code),     e.code);
        chk("err_count",    int'(err_count),    e.cnt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cur;
    int len;
    int r;
    reset_n = 1'b0;
    clr_err = 1'b0;
    {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = PA;
    model_reset();

    // Reset, then three nominal rounds
    for (int i = 0; i < 3; i++) drive(PA, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) nominal_round();

    // Overstayed A, then a normal remainder of the round
    hold(PA, 13); hold(PB, 4); hold(PC, 7); hold(PD, 4);

    // Short B
    hold(PA, 11); hold(PB, 2); hold(PC, 7); hold(PD, 4);

    // Conflicting greens, then resync on an untimed A
    hold(PGG, 3);
    nominal_round();

    // Skipped B
    hold(PA, 11); hold(PC, 7); hold(PD, 4); hold(PA, 11);
    drive(PB, 1'b1, 1'b1);
    hold(PB, 3); hold(PC, 7); hold(PD, 4);

    // Randomised segments: mostly ordered phases with jittered dwell,
    // occasional jumps, random lamp patterns and clear requests
    cur = 3;
    for (int s = 0; s < 60; s++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        len = int'($urandom_range(1, 3));
        for (int j = 0; j < len; j++) drive(6'($urandom_range(0, 63)), 1'b0, 1'b1);
      end else begin
        if (r == 1) cur = int'($urandom_range(0, 3));
        else        cur = (cur + 1) % 4;
        len = dur_tab[cur] + int'($urandom_range(0, 4)) - 2;
        for (int j = 0; j < len; j++)
          drive(pat_tab[cur], ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, 1'b1);
      end
    end

    // Error storm: A/C alternation raises an error every cycle
    for (int i = 0; i < 150; i++) begin
      drive(PA, 1'b0, 1'b1);
      drive(PC, 1'b0, 1'b1);
    end
    hold(PD, 2);
    drive(PD, 1'b1, 1'b1);
    hold(PA, 5);
    // Reset in the middle of a phase, then a clean round
    drive(PA, 1'b0, 1'b0);
    drive(PA, 1'b0, 1'b0);
    nominal_round();
    hold(PA, 3);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
